sorter_n: RTL

//  - Parametrised, fully pipelined bitonic sorting network for N_ELEM tuple_pair_t entries (AoC5 ranges {start,end}).
//  - Each beat is sorted ascending or descending, selected per beat.
//  - Valid/ready handshake on both sides; stalls propagate stage by stage, and empty stages collapse (no bubbles).
//  - Sits between the range loader and the range merger; replaces the fixed 8-entry sorter.

---
 rtl/sorter_n_pkg.sv | 29 ++
 rtl/sorter_n_stage.sv | 70 +++++++
 rtl/sorter_n.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sorter_n_pkg.sv
// Shared entry type, compare helper and flat-bus macros for the sorter_n bitonic network.
// Ranges are {range_start, range_end}; the packed layout puts start in the upper half.
`ifndef SORTER_N_PKG_MACROS
`define SORTER_N_PKG_MACROS
`define ARR_FLAT_WIDTH(n) ((n) * $bits(sorter_n_pkg::tuple_pair_t))
`define INDEX_FLAT(v, i) v[(i) * $bits(sorter_n_pkg::tuple_pair_t) +: $bits(sorter_n_pkg::tuple_pair_t)]
`endif

package sorter_n_pkg;

  localparam int VAL_W  = 64;
  localparam int PAIR_W = 2 * VAL_W;

  typedef struct packed {
    logic [VAL_W-1:0] range_start;
    logic [VAL_W-1:0] range_end;
  } tuple_pair_t;

  function automatic logic pair_gt(input tuple_pair_t a, input tuple_pair_t b);
    if (a.range_start != b.range_start) return a.range_start > b.range_start;
    return a.range_end > b.range_end;
  endfunction

  // a sits at the lower index; strict compare keeps equal entries in place
  function automatic logic cmp_swp(input tuple_pair_t a, input tuple_pair_t b, input logic up);
    return up ? pair_gt(a, b) : pair_gt(b, a);
  endfunction

endpackage

// File: rtl/sorter_n_stage.sv
// One register stage of the bitonic network: compare-exchange layer (P,Q) followed by
// data/asc/valid registers that load whenever the stage is allowed to advance.
module sorter_n_stage
  import sorter_n_pkg::*;
#(
  parameter int N_ELEM = 8,
  parameter int P      = 0,
  parameter int Q      = 0
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              flush,
  input  logic                              load,
  input  logic                              prev_valid,
  input  logic                              prev_asc,
  input  logic [`ARR_FLAT_WIDTH(N_ELEM)-1:0] prev_data,
  output logic                              valid_q,
  output logic                              asc_q,
  output logic [`ARR_FLAT_WIDTH(N_ELEM)-1:0] data_q
);

  localparam int FLAT_W = `ARR_FLAT_WIDTH(N_ELEM);

  logic              valid_d;
  logic              asc_d;
  logic [FLAT_W-1:0] data_d;
  logic [FLAT_W-1:0] cx_data;

  always_comb begin
    cx_data = prev_data;
    for (int i = 0; i < N_ELEM; i++) begin
      if (((i >> Q) & 1) == 0) begin
        if (cmp_swp(`INDEX_FLAT(prev_data, i), `INDEX_FLAT(prev_data, (i | (1 << Q))),
                    ((((i >> (P + 1)) & 1) == 0) ^ !prev_asc))) begin
          `INDEX_FLAT(cx_data, i)              = `INDEX_FLAT(prev_data, (i | (1 << Q)));
          `INDEX_FLAT(cx_data, (i | (1 << Q))) = `INDEX_FLAT(prev_data, i);
        end
      end
    end
  end

  // data and asc only move with a real beat so idle inputs never enter the registers
  always_comb begin
    valid_d = valid_q;
    asc_d   = asc_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = prev_valid;
      if (prev_valid) begin
        asc_d  = prev_asc;
        data_d = cx_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      asc_q   <= 1'b1;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      asc_q   <= asc_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/sorter_n.sv
// Fully pipelined bitonic sorter for N_ELEM ranges with per-beat direction and bubble-collapsing stalls.
// Define SORTER_N_PERF_EN to build the saturating perf_beats/perf_stalls counters; otherwise they read 0.
module sorter_n
  import sorter_n_pkg::*;
#(
  parameter int N_ELEM = 8,
  parameter int CNT_W  = 16
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_asc,
  input  logic [`ARR_FLAT_WIDTH(N_ELEM)-1:0] in_pairs_flat,
  input  logic                              flush,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [`ARR_FLAT_WIDTH(N_ELEM)-1:0] out_pairs_flat,
  output logic [CNT_W-1:0]                  occupancy,
  output logic [CNT_W-1:0]                  perf_beats,
  output logic [CNT_W-1:0]                  perf_stalls
);

  localparam int FLAT_W = `ARR_FLAT_WIDTH(N_ELEM);
  localparam int L      = $clog2(N_ELEM);
  localparam int S      = L * (L + 1) / 2;

  logic [FLAT_W-1:0] stage_data [0:S];
  logic [S:0]        stage_valid;
  logic [S:0]        stage_asc;
  logic [S+1:1]      adv;
  logic              in_xfer;
  logic              out_xfer;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic              unused_last_asc;

  assign stage_data[0]  = in_pairs_flat;
  assign stage_valid[0] = in_valid;
  assign stage_asc[0]   = in_asc;

  // a stage may load when it is empty or its successor is loading this cycle
  always_comb begin
    adv[S+1] = out_ready;
    for (int k = S; k >= 1; k--) begin
      adv[k] = !stage_valid[k] || adv[k+1];
    end
  end

  for (genvar p = 0; p < L; p++) begin : g_p
    for (genvar q = p; q >= 0; q--) begin : g_q
      localparam int K = p * (p + 1) / 2 + (p - q) + 1;
      sorter_n_stage #(
        .N_ELEM (N_ELEM),
        .P      (p),
        .Q      (q)
      ) u_stage (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .load       (adv[K]),
        .prev_valid (stage_valid[K-1]),
        .prev_asc   (stage_asc[K-1]),
        .prev_data  (stage_data[K-1]),
        .valid_q    (stage_valid[K]),
        .asc_q      (stage_asc[K]),
        .data_q     (stage_data[K])
      );
    end
  end

  assign unused_last_asc = stage_asc[S];

  assign in_ready       = adv[1];
  assign out_valid      = stage_valid[S];
  assign out_pairs_flat = stage_data[S];
  assign in_xfer        = in_valid && in_ready;
  assign out_xfer       = out_valid && out_ready;

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (in_xfer && !out_xfer) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (!in_xfer && out_xfer) begin
      occ_d = occ_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

`ifdef SORTER_N_PERF_EN
  logic [CNT_W-1:0] beats_q, beats_d;
  logic [CNT_W-1:0] stalls_q, stalls_d;

  // counters saturate and are deliberately left untouched by flush
  always_comb begin
    beats_d  = beats_q;
    stalls_d = stalls_q;
    if (in_xfer && !flush && (beats_q != '1)) begin
      beats_d = beats_q + CNT_W'(1);
    end
    if (out_valid && !out_ready && (stalls_q != '1)) begin
      stalls_d = stalls_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beats_q  <= '0;
      stalls_q <= '0;
    end else begin
      beats_q  <= beats_d;
      stalls_q <= stalls_d;
    end
  end

  assign perf_beats  = beats_q;
  assign perf_stalls = stalls_q;
`else
  assign perf_beats  = '0;
  assign perf_stalls = '0;
`endif

endmodule
